// File: rtl/pdp_mem_arbiter_if.sv
// pdp_mem_arbiter_if
// Bundles the fetch read port, the exec read/write ports and the
// single-ported memory bus seen by pdp_mem_arbiter.
//   slave  : arbiter side
//   master : requestors plus memory model side
interface pdp_mem_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 12
);
    logic              ifu_rd_req;
    logic [ADDR_W-1:0] ifu_rd_addr;
    logic [DATA_W-1:0] ifu_rd_data;
    logic              ifu_rd_valid;

    logic              exec_rd_req;
    logic [ADDR_W-1:0] exec_rd_addr;
    logic [DATA_W-1:0] exec_rd_data;
    logic              exec_rd_valid;

    logic              exec_wr_req;
    logic [ADDR_W-1:0] exec_wr_addr;
    logic [DATA_W-1:0] exec_wr_data;
    logic              exec_wr_ack;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  ifu_rd_req, ifu_rd_addr,
        output ifu_rd_data, ifu_rd_valid,
        input  exec_rd_req, exec_rd_addr,
        output exec_rd_data, exec_rd_valid,
        input  exec_wr_req, exec_wr_addr, exec_wr_data,
        output exec_wr_ack,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output ifu_rd_req, ifu_rd_addr,
        input  ifu_rd_data, ifu_rd_valid,
        output exec_rd_req, exec_rd_addr,
        input  exec_rd_data, exec_rd_valid,
        output exec_wr_req, exec_wr_addr, exec_wr_data,
        input  exec_wr_ack,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/pdp_mem_arbiter.sv
// pdp_mem_arbiter
// Serialises fetch reads, exec reads and exec writes onto one single-ported
// memory. Exec write > exec read > fetch, except that once MAX_EXEC_BURST
// exec grants have gone by with a fetch waiting, the fetch wins.
// Optional statistics counters are enabled by defining PDP_ARB_STATS_EN.
module pdp_mem_arbiter #(
    parameter int ADDR_W         = 12,
    parameter int DATA_W         = 12,
    parameter int MAX_EXEC_BURST = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    pdp_mem_arbiter_if.slave   bus,
`ifdef PDP_ARB_STATS_EN
    output logic [15:0]        stat_ifu_grants,
    output logic [15:0]        stat_exec_grants,
    output logic [15:0]        stat_conflict_cycles,
`endif
    output logic               arb_busy
);

    localparam int CNT_W = $clog2(MAX_EXEC_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_EXEC_BURST);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RD_WAIT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        PORT_IFU = 2'd0,
        PORT_ERD = 2'd1,
        PORT_EWR = 2'd2
    } port_t;

    state_t            state_r;
    port_t             port_r;
    logic [CNT_W-1:0]  burst_r;

    logic              ifu_rd_valid_r;
    logic              exec_rd_valid_r;
    logic              exec_wr_ack_r;
    logic [DATA_W-1:0] ifu_rd_data_r;
    logic [DATA_W-1:0] exec_rd_data_r;
    logic              mem_req_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              arb_busy_r;

    logic              ifu_act_s;
    logic              erd_act_s;
    logic              ewr_act_s;
    logic              grant_s;
    port_t             grant_port_s;
    logic [ADDR_W-1:0] grant_addr_s;

    assign bus.ifu_rd_valid  = ifu_rd_valid_r;
    assign bus.ifu_rd_data   = ifu_rd_data_r;
    assign bus.exec_rd_valid = exec_rd_valid_r;
    assign bus.exec_rd_data  = exec_rd_data_r;
    assign bus.exec_wr_ack   = exec_wr_ack_r;
    assign bus.mem_req       = mem_req_r;
    assign bus.mem_we        = mem_we_r;
    assign bus.mem_addr      = mem_addr_r;
    assign bus.mem_wdata     = mem_wdata_r;
    assign arb_busy          = arb_busy_r;

    // Pick the winner among live requests; a port whose completion pulse is
    // high this cycle is still showing its old request, so it is masked.
    always_comb begin
        ifu_act_s    = bus.ifu_rd_req  && !ifu_rd_valid_r;
        erd_act_s    = bus.exec_rd_req && !exec_rd_valid_r;
        ewr_act_s    = bus.exec_wr_req && !exec_wr_ack_r;
        grant_s      = 1'b0;
        grant_port_s = PORT_IFU;
        grant_addr_s = bus.ifu_rd_addr;
        if (ifu_act_s && (burst_r == BURST_MAX)) begin
            grant_s      = 1'b1;
            grant_port_s = PORT_IFU;
            grant_addr_s = bus.ifu_rd_addr;
        end else if (ewr_act_s) begin
            grant_s      = 1'b1;
            grant_port_s = PORT_EWR;
            grant_addr_s = bus.exec_wr_addr;
        end else if (erd_act_s) begin
            grant_s      = 1'b1;
            grant_port_s = PORT_ERD;
            grant_addr_s = bus.exec_rd_addr;
        end else if (ifu_act_s) begin
            grant_s      = 1'b1;
            grant_port_s = PORT_IFU;
            grant_addr_s = bus.ifu_rd_addr;
        end else begin
            grant_s      = 1'b0;
            grant_port_s = PORT_IFU;
            grant_addr_s = bus.ifu_rd_addr;
        end
    end

    // Count consecutive exec grants made while a fetch is waiting.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            burst_r <= '0;
        end else if (!bus.ifu_rd_req) begin
            burst_r <= '0;
        end else if ((state_r == ST_IDLE) && grant_s && (grant_port_s == PORT_IFU)) begin
            burst_r <= '0;
        end else if ((state_r == ST_IDLE) && grant_s && (burst_r != BURST_MAX)) begin
            burst_r <= burst_r + CNT_W'(1);
        end else begin
            burst_r <= burst_r;
        end
    end

    // Access sequencer: grant in IDLE, strobe memory in ISSUE, capture read
    // data in RD_WAIT; every output is registered here.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r         <= ST_IDLE;
            port_r          <= PORT_IFU;
            ifu_rd_valid_r  <= 1'b0;
            exec_rd_valid_r <= 1'b0;
            exec_wr_ack_r   <= 1'b0;
            ifu_rd_data_r   <= '0;
            exec_rd_data_r  <= '0;
            mem_req_r       <= 1'b0;
            mem_we_r        <= 1'b0;
            mem_addr_r      <= '0;
            mem_wdata_r     <= '0;
            arb_busy_r      <= 1'b0;
        end else begin
            ifu_rd_valid_r  <= 1'b0;
            exec_rd_valid_r <= 1'b0;
            exec_wr_ack_r   <= 1'b0;
            mem_req_r       <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (grant_s) begin
                        port_r     <= grant_port_s;
                        mem_req_r  <= 1'b1;
                        mem_we_r   <= (grant_port_s == PORT_EWR);
                        mem_addr_r <= grant_addr_s;
                        if (grant_port_s == PORT_EWR) begin
                            mem_wdata_r <= bus.exec_wr_data;
                        end else begin
                            mem_wdata_r <= mem_wdata_r;
                        end
                        state_r    <= ST_ISSUE;
                        arb_busy_r <= 1'b1;
                    end else begin
                        state_r    <= ST_IDLE;
                        arb_busy_r <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (mem_we_r) begin
                        exec_wr_ack_r <= 1'b1;
                        state_r       <= ST_IDLE;
                        arb_busy_r    <= 1'b0;
                    end else begin
                        state_r       <= ST_RD_WAIT;
                        arb_busy_r    <= 1'b1;
                    end
                end
                ST_RD_WAIT: begin
                    case (port_r)
                        PORT_IFU: begin
                            ifu_rd_data_r  <= bus.mem_rdata;
                            ifu_rd_valid_r <= 1'b1;
                        end
                        PORT_ERD: begin
                            exec_rd_data_r  <= bus.mem_rdata;
                            exec_rd_valid_r <= 1'b1;
                        end
                        default: begin
                            ifu_rd_valid_r <= 1'b0;
                        end
                    endcase
                    state_r    <= ST_IDLE;
                    arb_busy_r <= 1'b0;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    arb_busy_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef PDP_ARB_STATS_EN
    // Saturating grant and fetch-vs-exec conflict counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stat_ifu_grants      <= 16'h0000;
            stat_exec_grants     <= 16'h0000;
            stat_conflict_cycles <= 16'h0000;
        end else if (state_r == ST_IDLE) begin
            if (grant_s && (grant_port_s == PORT_IFU) && (stat_ifu_grants != 16'hFFFF)) begin
                stat_ifu_grants <= stat_ifu_grants + 16'h0001;
            end else begin
                stat_ifu_grants <= stat_ifu_grants;
            end
            if (grant_s && (grant_port_s != PORT_IFU) && (stat_exec_grants != 16'hFFFF)) begin
                stat_exec_grants <= stat_exec_grants + 16'h0001;
            end else begin
                stat_exec_grants <= stat_exec_grants;
            end
            if (bus.ifu_rd_req && (bus.exec_rd_req || bus.exec_wr_req)
                && (stat_conflict_cycles != 16'hFFFF)) begin
                stat_conflict_cycles <= stat_conflict_cycles + 16'h0001;
            end else begin
                stat_conflict_cycles <= stat_conflict_cycles;
            end
        end else begin
            stat_ifu_grants      <= stat_ifu_grants;
            stat_exec_grants     <= stat_exec_grants;
            stat_conflict_cycles <= stat_conflict_cycles;
        end
    end
`endif

endmodule

// File: tb/tb_pdp_mem_arbiter.sv
// tb_pdp_mem_arbiter
// Directed bench for pdp_mem_arbiter with a small behavioural memory.
// Inputs are driven and outputs sampled on the falling clock edge.
// Build with PDP_ARB_STATS_EN defined to also exercise the statistics counters.
module tb_pdp_mem_arbiter;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    logic        pl_en;
    logic [11:0] pl_addr;
    logic [11:0] pl_data;
    logic [11:0] mem [0:4095];
    logic        arb_busy;

`ifdef PDP_ARB_STATS_EN
    logic [15:0] stat_ifu_grants;
    logic [15:0] stat_exec_grants;
    logic [15:0] stat_conflict_cycles;
`endif

    pdp_mem_arbiter_if #(.ADDR_W(12), .DATA_W(12)) bus ();

    pdp_mem_arbiter #(
        .ADDR_W(12),
        .DATA_W(12),
        .MAX_EXEC_BURST(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus),
`ifdef PDP_ARB_STATS_EN
        .stat_ifu_grants(stat_ifu_grants),
        .stat_exec_grants(stat_exec_grants),
        .stat_conflict_cycles(stat_conflict_cycles),
`endif
        .arb_busy(arb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: read data appears the cycle after a read strobe.
    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (bus.mem_req) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic drop_all();
        bus.ifu_rd_req  = 1'b0;
        bus.exec_rd_req = 1'b0;
        bus.exec_wr_req = 1'b0;
    endtask

    task automatic preload(input logic [11:0] a, input logic [11:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        wait_neg(1);
        pl_en = 1'b0;
    endtask

    task automatic test_reset();
        bus.ifu_rd_req   = 1'b1; bus.ifu_rd_addr  = 12'o0200;
        bus.exec_rd_req  = 1'b1; bus.exec_rd_addr = 12'o0050;
        bus.exec_wr_req  = 1'b1; bus.exec_wr_addr = 12'o0100; bus.exec_wr_data = 12'o0777;
        wait_neg(2);
        checks++;
        if ({bus.mem_req, bus.mem_we, arb_busy} !== 3'b000) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=000", {bus.mem_req, bus.mem_we, arb_busy});
        end
        checks++;
        if ({bus.ifu_rd_valid, bus.exec_rd_valid, bus.exec_wr_ack} !== 3'b000) begin
            failures++; $display("FAIL reset_pulses got=%b exp=000",
                {bus.ifu_rd_valid, bus.exec_rd_valid, bus.exec_wr_ack});
        end
        checks++;
        if ({bus.mem_addr, bus.mem_wdata, bus.ifu_rd_data, bus.exec_rd_data} !== 48'h0) begin
            failures++; $display("FAIL reset_data got=%h exp=0",
                {bus.mem_addr, bus.mem_wdata, bus.ifu_rd_data, bus.exec_rd_data});
        end
        reset_n = 1'b1;
        wait_neg(1);
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b1, 12'o0100, 12'o0777}) begin
            failures++; $display("FAIL reset_first_grant got=%b%b %o %o exp=11 0100 0777",
                bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        wait_neg(1);
        checks++;
        if (bus.exec_wr_ack !== 1'b1) begin
            failures++; $display("FAIL reset_first_ack got=%b exp=1", bus.exec_wr_ack);
        end
        drop_all();
        wait_neg(4);
    endtask

    task automatic test_single_fetch();
        bus.ifu_rd_req = 1'b1; bus.ifu_rd_addr = 12'o0200;
        wait_neg(1);
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr, arb_busy} !== {1'b1, 1'b0, 12'o0200, 1'b1}) begin
            failures++; $display("FAIL fetch_issue got=%b%b %o busy=%b exp=10 0200 busy=1",
                bus.mem_req, bus.mem_we, bus.mem_addr, arb_busy);
        end
        wait_neg(1);
        checks++;
        if ({bus.mem_req, bus.ifu_rd_valid} !== 2'b00) begin
            failures++; $display("FAIL fetch_wait got=%b exp=00", {bus.mem_req, bus.ifu_rd_valid});
        end
        wait_neg(1);
        checks++;
        if ({bus.ifu_rd_valid, bus.ifu_rd_data} !== {1'b1, 12'o7402}) begin
            failures++; $display("FAIL fetch_valid got=%b %o exp=1 7402", bus.ifu_rd_valid, bus.ifu_rd_data);
        end
        bus.ifu_rd_req = 1'b0;
        wait_neg(1);
        checks++;
        if ({bus.ifu_rd_valid, bus.ifu_rd_data, arb_busy} !== {1'b0, 12'o7402, 1'b0}) begin
            failures++; $display("FAIL fetch_hold got=%b %o busy=%b exp=0 7402 busy=0",
                bus.ifu_rd_valid, bus.ifu_rd_data, arb_busy);
        end
        wait_neg(2);
    endtask

    task automatic test_write_then_read();
        bus.exec_wr_req = 1'b1; bus.exec_wr_addr = 12'o0050; bus.exec_wr_data = 12'o1234;
        bus.exec_rd_req = 1'b1; bus.exec_rd_addr = 12'o0050;
        wait_neg(1);
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b1, 12'o0050}) begin
            failures++; $display("FAIL wtr_write_issue got=%b%b %o exp=11 0050",
                bus.mem_req, bus.mem_we, bus.mem_addr);
        end
        wait_neg(1);
        checks++;
        if ({bus.exec_wr_ack, bus.exec_rd_valid} !== 2'b10) begin
            failures++; $display("FAIL wtr_ack got=%b exp=10", {bus.exec_wr_ack, bus.exec_rd_valid});
        end
        bus.exec_wr_req = 1'b0;
        wait_neg(1);
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.exec_wr_ack} !== 3'b100) begin
            failures++; $display("FAIL wtr_read_issue got=%b exp=100", {bus.mem_req, bus.mem_we, bus.exec_wr_ack});
        end
        wait_neg(2);
        checks++;
        if ({bus.exec_rd_valid, bus.exec_rd_data} !== {1'b1, 12'o1234}) begin
            failures++; $display("FAIL wtr_read_data got=%b %o exp=1 1234", bus.exec_rd_valid, bus.exec_rd_data);
        end
        bus.exec_rd_req = 1'b0;
        wait_neg(3);
    endtask

    task automatic test_starvation();
        logic [1:0] exp_seq [10];
        logic [1:0] got_seq [10];
        int         n_grants;
        int         cyc;
        exp_seq[0] = 2'd2; exp_seq[1] = 2'd1; exp_seq[2] = 2'd2; exp_seq[3] = 2'd1; exp_seq[4] = 2'd0;
        exp_seq[5] = 2'd2; exp_seq[6] = 2'd1; exp_seq[7] = 2'd2; exp_seq[8] = 2'd1; exp_seq[9] = 2'd0;
        for (int i = 0; i < 10; i++) got_seq[i] = 2'd3;
        n_grants = 0;
        cyc      = 0;
        bus.ifu_rd_req  = 1'b1; bus.ifu_rd_addr  = 12'o0300;
        bus.exec_rd_req = 1'b1; bus.exec_rd_addr = 12'o0060;
        bus.exec_wr_req = 1'b1; bus.exec_wr_addr = 12'o0070; bus.exec_wr_data = 12'o0123;
        while ((n_grants < 10) && (cyc < 100)) begin
            wait_neg(1);
            cyc++;
            if (bus.mem_req === 1'b1) begin
                if (bus.mem_we === 1'b1)                got_seq[n_grants] = 2'd2;
                else if (bus.mem_addr === 12'o0060)     got_seq[n_grants] = 2'd1;
                else if (bus.mem_addr === 12'o0300)     got_seq[n_grants] = 2'd0;
                else                                    got_seq[n_grants] = 2'd3;
                n_grants++;
            end
        end
        bus.exec_rd_req = 1'b0;
        bus.exec_wr_req = 1'b0;
        checks++;
        if (n_grants != 10) begin
            failures++; $display("FAIL starve_grant_count got=%0d exp=10", n_grants);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (got_seq[i] !== exp_seq[i]) begin
                failures++; $display("FAIL starve_grant_%0d got=%0d exp=%0d (0=fetch 1=exec_rd 2=exec_wr)",
                    i, got_seq[i], exp_seq[i]);
            end
        end
        wait_neg(2);
        bus.ifu_rd_req = 1'b0;
        wait_neg(4);
    endtask

    task automatic test_midop_reset();
        bus.exec_rd_req = 1'b1; bus.exec_rd_addr = 12'o0200;
        wait_neg(1);
        checks++;
        if (bus.mem_req !== 1'b1) begin
            failures++; $display("FAIL midrst_issue got=%b exp=1", bus.mem_req);
        end
        wait_neg(1);
        reset_n = 1'b0;
        bus.exec_rd_req = 1'b0;
        wait_neg(1);
        checks++;
        if ({bus.exec_rd_valid, arb_busy, bus.mem_req, bus.exec_rd_data} !== {3'b000, 12'o0000}) begin
            failures++; $display("FAIL midrst_abort got=%b%b%b %o exp=000 0000",
                bus.exec_rd_valid, arb_busy, bus.mem_req, bus.exec_rd_data);
        end
        reset_n = 1'b1;
        wait_neg(1);
        checks++;
        if ({bus.exec_rd_valid, arb_busy} !== 2'b00) begin
            failures++; $display("FAIL midrst_after got=%b exp=00", {bus.exec_rd_valid, arb_busy});
        end
        wait_neg(2);
    endtask

`ifdef PDP_ARB_STATS_EN
    task automatic test_stats();
        // One conflict cycle: fetch and write together, write wins first.
        bus.ifu_rd_req  = 1'b1; bus.ifu_rd_addr  = 12'o0200;
        bus.exec_wr_req = 1'b1; bus.exec_wr_addr = 12'o0400; bus.exec_wr_data = 12'o0011;
        wait_neg(2);
        bus.exec_wr_req = 1'b0;
        wait_neg(3);
        bus.ifu_rd_req = 1'b0;
        wait_neg(1);
        bus.exec_wr_req = 1'b1; bus.exec_wr_addr = 12'o0401; bus.exec_wr_data = 12'o0022;
        wait_neg(2);
        bus.exec_wr_req = 1'b0;
        wait_neg(1);
        for (int k = 0; k < 2; k++) begin
            bus.ifu_rd_req = 1'b1; bus.ifu_rd_addr = 12'o0200;
            wait_neg(3);
            bus.ifu_rd_req = 1'b0;
            wait_neg(1);
        end
        checks++;
        if ({stat_ifu_grants, stat_exec_grants, stat_conflict_cycles} !== {16'd3, 16'd2, 16'd1}) begin
            failures++; $display("FAIL stats got=%0d,%0d,%0d exp=3,2,1",
                stat_ifu_grants, stat_exec_grants, stat_conflict_cycles);
        end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        pl_en    = 1'b0;
        pl_addr  = 12'o0000;
        pl_data  = 12'o0000;
        bus.mem_rdata    = 12'o0000;
        bus.ifu_rd_addr  = 12'o0000;
        bus.exec_rd_addr = 12'o0000;
        bus.exec_wr_addr = 12'o0000;
        bus.exec_wr_data = 12'o0000;
        drop_all();
        wait_neg(1);
        preload(12'o0200, 12'o7402);
        preload(12'o0300, 12'o5555);
        preload(12'o0060, 12'o4321);
        test_reset();
        test_single_fetch();
        test_write_then_read();
        test_starvation();
        test_midop_reset();
`ifdef PDP_ARB_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
